// File: rtl/axil_cfg_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI-Lite transaction
// out, one response back. Misaligned commands are answered locally with SLVERR.
module axil_cfg_master #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  // Command side
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_we,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  // Response side
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [7:0]                err_count,
  // AXI4-Lite write address / data / response
  output logic [ADDR_WIDTH-1:0]     M_AWADDR,
  output logic                      M_AWVALID,
  input  logic                      M_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_WSTRB,
  output logic                      M_WVALID,
  input  logic                      M_WREADY,
  input  logic [1:0]                M_BRESP,
  input  logic                      M_BVALID,
  output logic                      M_BREADY,
  // AXI4-Lite read address / data
  output logic [ADDR_WIDTH-1:0]     M_ARADDR,
  output logic                      M_ARVALID,
  input  logic                      M_ARREADY,
  input  logic [DATA_WIDTH-1:0]     M_RDATA,
  input  logic [1:0]                M_RRESP,
  input  logic                      M_RVALID,
  output logic                      M_RREADY,
  // Debug: current FSM state
  output logic [2:0]                dbg_state
);

  // Handshake rule on every channel here: a beat transfers on a rising edge
  // where VALID and READY are both high; VALID never waits on READY and the
  // payload is held stable from VALID rising until that edge.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_RESP = 3'd4,
    S_RSP     = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t                    state_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH/8-1:0]   wstrb_q;
  logic                      aw_done_q;
  logic                      w_done_q;
  logic                      awvalid_q;
  logic                      wvalid_q;
  logic                      bready_q;
  logic                      arvalid_q;
  logic                      rready_q;
  logic                      rsp_valid_q;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q;
  logic [1:0]                rsp_resp_q;
  logic [7:0]                err_count_q;

  logic                      aw_hs;
  logic                      w_hs;
  logic                      aw_all;
  logic                      w_all;
  logic [7:0]                err_count_d;

  always_comb begin
    aw_hs       = awvalid_q & M_AWREADY;
    w_hs        = wvalid_q & M_WREADY;
    aw_all      = aw_done_q | aw_hs;
    w_all       = w_done_q | w_hs;
    err_count_d = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
      err_count_q <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            if (cmd_addr[1:0] != 2'b00) begin
              // Misaligned: answer locally, never touch the bus.
              state_q     <= S_RSP;
              rsp_valid_q <= 1'b1;
              rsp_resp_q  <= RESP_SLVERR;
              rsp_rdata_q <= '0;
              err_count_q <= err_count_d;
            end else if (cmd_we) begin
              state_q   <= S_WR_REQ;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= S_RD_REQ;
              arvalid_q <= 1'b1;
            end
          end
        end
        S_WR_REQ: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_all && w_all) begin
            state_q  <= S_WR_RESP;
            bready_q <= 1'b1;
          end
        end
        S_WR_RESP: begin
          if (M_BVALID) begin
            state_q     <= S_RSP;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_resp_q  <= M_BRESP;
            rsp_rdata_q <= '0;
            if (M_BRESP != RESP_OKAY) err_count_q <= err_count_d;
          end
        end
        S_RD_REQ: begin
          if (M_ARREADY) begin
            state_q   <= S_RD_RESP;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        S_RD_RESP: begin
          if (M_RVALID) begin
            state_q     <= S_RSP;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_resp_q  <= M_RRESP;
            rsp_rdata_q <= M_RDATA;
            if (M_RRESP != RESP_OKAY) err_count_q <= err_count_d;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // cmd_ready is gated by ARESET so it reads 0 for the whole reset window.
  assign cmd_ready = (state_q == S_IDLE) & ~ARESET;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign err_count = err_count_q;

  assign M_AWADDR  = addr_q;
  assign M_AWVALID = awvalid_q;
  assign M_WDATA   = wdata_q;
  assign M_WSTRB   = wstrb_q;
  assign M_WVALID  = wvalid_q;
  assign M_BREADY  = bready_q;
  assign M_ARADDR  = addr_q;
  assign M_ARVALID = arvalid_q;
  assign M_RREADY  = rready_q;
  assign dbg_state = state_q;

endmodule
